// File: rtl/slc3_pkg.sv
// Shared SLC-3 definitions for the branch resolution path: FSM states,
// condition-code bit positions and the BR offset width.
package slc3_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    TARGET = 2'd2,
    DONE   = 2'd3
  } br_state_t;

  localparam int CC_N   = 2;
  localparam int CC_Z   = 1;
  localparam int CC_P   = 0;
  localparam int OFF9_W = 9;

endpackage

// File: rtl/cc_reg.sv
// Condition-code register: load-enabled {N,Z,P} holder, resets to Z.
module cc_reg (
  input  logic       clk_i,
  input  logic       srst_i,
  input  logic       ld_i,
  input  logic [2:0] d_i,
  output logic [2:0] q_o
);

  logic [2:0] cc_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cc_q <= 3'b010;
    end else if (ld_i) begin
      cc_q <= d_i;
    end
  end

  assign q_o = cc_q;

endmodule

// File: rtl/branch_unit.sv
// Branch resolution stage: captures the condition codes, evaluates a BR
// instruction on request and produces the taken target with a PC-load pulse.
module branch_unit
  import slc3_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        LD_CC,
  input  logic [2:0]  nzp_in,
  input  logic [15:0] IR,
  input  logic [15:0] PC,
  input  logic        start,
  output logic [2:0]  nzp_q,
  output logic        BEN,
  output logic        busy,
  output logic        done,
  output logic        LD_PC,
  output logic [15:0] PC_target
);

  br_state_t          state_q, state_d;
  logic [2:0]         ir_cond_q;
  logic [OFF9_W-1:0]  off9_q;
  logic [15:0]        pc_lat_q;
  logic               ben_q;
  logic [15:0]        target_q;
  logic               cond_hit;
  logic [15:0]        off_sext;
  logic               ir_unused;

  // The opcode nibble is decoded by the ISDU, not here.
  assign ir_unused = ^IR[15:12];

  cc_reg u_cc_reg (
    .clk_i  (Clk),
    .srst_i (Reset),
    .ld_i   (LD_CC),
    .d_i    (nzp_in),
    .q_o    (nzp_q)
  );

  assign cond_hit = (ir_cond_q[CC_N] & nzp_q[CC_N]) |
                    (ir_cond_q[CC_Z] & nzp_q[CC_Z]) |
                    (ir_cond_q[CC_P] & nzp_q[CC_P]);

  assign off_sext = {{(16 - OFF9_W){off9_q[OFF9_W-1]}}, off9_q};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = EVAL;
      EVAL:    state_d = cond_hit ? TARGET : DONE;
      TARGET:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      ir_cond_q <= 3'b000;
      off9_q    <= '0;
      pc_lat_q  <= 16'h0000;
      ben_q     <= 1'b0;
      target_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        ir_cond_q <= IR[11:9];
        off9_q    <= IR[OFF9_W-1:0];
        pc_lat_q  <= PC;
      end
      if (state_q == EVAL) begin
        ben_q <= cond_hit;
      end
      // Modulo-2^16 add: a carry out of bit 15 is simply discarded.
      if (state_q == TARGET) begin
        target_q <= pc_lat_q + off_sext;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign LD_PC     = (state_q == DONE) & ben_q;
  assign BEN       = ben_q;
  assign PC_target = target_q;

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed vector table, reset corner
// case and randomized transactions against a behavioural model.
module tb_branch_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        LD_CC = 1'b0;
  logic [2:0]  nzp_in = 3'b000;
  logic [15:0] IR = 16'h0000;
  logic [15:0] PC = 16'h0000;
  logic        start = 1'b0;
  logic [2:0]  nzp_q;
  logic        BEN, busy, done, LD_PC;
  logic [15:0] PC_target;

  int total = 0;
  int bad = 0;

  // Behavioural model state.
  logic [2:0]  m_nzp;
  logic        m_ben;
  logic [15:0] m_tgt;

  always #5 Clk = ~Clk;

  branch_unit dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .LD_CC     (LD_CC),
    .nzp_in    (nzp_in),
    .IR        (IR),
    .PC        (PC),
    .start     (start),
    .nzp_q     (nzp_q),
    .BEN       (BEN),
    .busy      (busy),
    .done      (done),
    .LD_PC     (LD_PC),
    .PC_target (PC_target)
  );

  typedef struct {
    logic [1:0]  mode;     // 0: no CC load, 1: load before start, 2: load with start
    logic [2:0]  nzp;
    logic [15:0] ir;
    logic [15:0] pc;
    logic        exp_ben;
    logic [15:0] exp_tgt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Higher-level model: signed offset added with integer arithmetic.
  function automatic logic [15:0] model_target(input logic [15:0] pc, input logic [15:0] ir);
    int off;
    off = int'(ir[8:0]);
    if (off >= 256) off = off - 512;
    return 16'((int'(pc) + off + 65536) % 65536);
  endfunction

  // One BR transaction; ldcc_eval loads eval_nzp into CC while the unit is in EVAL.
  task automatic do_br(input logic [1:0] mode, input logic [2:0] nzp, input logic [15:0] ir,
                       input logic [15:0] pc, input logic exp_ben, input logic [15:0] exp_tgt,
                       input logic noisy, input logic ldcc_eval, input logic [2:0] eval_nzp,
                       input logic [2:0] exp_nzp_after);
    int edges;
    int exp_lat;
    exp_lat = exp_ben ? 3 : 2;
    @(negedge Clk);
    if (mode == 2'd1) begin
      LD_CC = 1'b1; nzp_in = nzp;
      @(negedge Clk);
      LD_CC = 1'b0;
    end
    IR = ir; PC = pc; start = 1'b1;
    if (mode == 2'd2) begin
      LD_CC = 1'b1; nzp_in = nzp;
    end
    @(negedge Clk);
    start = 1'b0; LD_CC = 1'b0;
    edges = 1;
    while (!done && edges < 8) begin
      chk("busy_during", {31'd0, busy}, 32'd1);
      if (noisy) begin
        start = 1'b1; IR = 16'(~ir); PC = 16'(~pc);
      end
      if (ldcc_eval && edges == 1) begin
        LD_CC = 1'b1; nzp_in = eval_nzp;
      end
      @(negedge Clk);
      start = 1'b0; LD_CC = 1'b0;
      edges++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("latency", edges, exp_lat);
    chk("ld_pc", {31'd0, LD_PC}, {31'd0, exp_ben});
    chk("ben", {31'd0, BEN}, {31'd0, exp_ben});
    chk("pc_target", {16'd0, PC_target}, {16'd0, exp_tgt});
    chk("busy_at_done", {31'd0, busy}, 32'd1);
    @(negedge Clk);
    chk("done_drop", {30'd0, done, LD_PC}, 32'd0);
    chk("idle_after", {31'd0, busy}, 32'd0);
    chk("nzp_after", {29'd0, nzp_q}, {29'd0, exp_nzp_after});
  endtask

  vec_t vecs[6];
  int   extra_done;

  initial begin
    vecs[0] = '{2'd1, 3'b100, 16'h0805, 16'h3000, 1'b1, 16'h3005};
    vecs[1] = '{2'd1, 3'b001, 16'h09FF, 16'h3000, 1'b0, 16'h3005};
    vecs[2] = '{2'd2, 3'b010, 16'h0400, 16'hFFFF, 1'b1, 16'hFFFF};
    vecs[3] = '{2'd2, 3'b010, 16'h0401, 16'hFFFF, 1'b1, 16'h0000};
    vecs[4] = '{2'd1, 3'b111, 16'h0000, 16'h1234, 1'b0, 16'h0000};
    vecs[5] = '{2'd1, 3'b001, 16'h0E00, 16'h1234, 1'b1, 16'h1234};

    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("rst_nzp", {29'd0, nzp_q}, 32'd2);
    chk("rst_flags", {28'd0, BEN, busy, done, LD_PC}, 32'd0);
    chk("rst_target", {16'd0, PC_target}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      do_br(vecs[i].mode, vecs[i].nzp, vecs[i].ir, vecs[i].pc, vecs[i].exp_ben,
            vecs[i].exp_tgt, 1'b0, 1'b0, 3'b000, vecs[i].nzp);
      $display("vec %0d ir=%h pc=%h nzp=%b ben=%b tgt=%h", i, vecs[i].ir, vecs[i].pc,
               vecs[i].nzp, BEN, PC_target);
    end

    // Starts while busy ignored; CC load during EVAL does not alter that evaluation.
    do_br(2'd1, 3'b100, 16'h0810, 16'h4000, 1'b1, 16'h4010, 1'b1, 1'b1, 3'b001, 3'b001);
    extra_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      if (done) extra_done++;
    end
    chk("single_done", extra_done, 0);
    $display("busy-start seq ben=%b tgt=%h nzp=%b", BEN, PC_target, nzp_q);

    // Reset while in TARGET.
    @(negedge Clk);
    LD_CC = 1'b1; nzp_in = 3'b100;
    @(negedge Clk);
    LD_CC = 1'b0; IR = 16'h0803; PC = 16'h5000; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_nzp", {29'd0, nzp_q}, 32'd2);
    chk("rstmid_ben_tgt", {15'd0, BEN, PC_target}, 32'd0);
    extra_done = 0;
    for (int i = 0; i < 4; i++) begin
      if (done || LD_PC) extra_done++;
      @(negedge Clk);
    end
    chk("rstmid_no_done", extra_done, 0);
    $display("reset-in-TARGET seq busy=%b nzp=%b", busy, nzp_q);

    m_nzp = 3'b010; m_ben = 1'b0; m_tgt = 16'h0000;
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  mode;
      logic [2:0]  nzp, enzp;
      logic [15:0] ir, pc;
      logic        taken, noisy, le;
      mode  = 2'($urandom_range(0, 2));
      nzp   = 3'($urandom);
      ir    = 16'($urandom);
      pc    = 16'($urandom);
      noisy = 1'($urandom);
      le    = 1'($urandom);
      enzp  = 3'($urandom);
      if (mode != 2'd0) m_nzp = nzp;
      taken = ((ir[11:9] & m_nzp) != 3'b000);
      m_ben = taken;
      if (taken) m_tgt = model_target(pc, ir);
      if (le) m_nzp = enzp;
      do_br(mode, nzp, ir, pc, m_ben, m_tgt, noisy, le, enzp, m_nzp);
      $display("rand %0d ir=%h pc=%h ben=%b tgt=%h", i, ir, pc, BEN, PC_target);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
